// File: rtl/segre_decode_queue.sv
// segre_decode_queue: DEPTH-entry instruction queue feeding an RV32I decoder
// with a registered output bundle behind a valid/ready handshake.
module segre_decode_queue #(
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned REG_SIZE         = 5,
    parameter int unsigned DEPTH            = 4,
    parameter bit          STALL_ON_ILLEGAL = 1'b1,
    parameter bit          SUPPRESS_X0_WE   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 fetch_valid_i,
    output logic                 fetch_ready_o,
    input  logic [WORD_SIZE-1:0] fetch_instr_i,
    input  logic [WORD_SIZE-1:0] fetch_pc_i,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [WORD_SIZE-1:0] dec_pc_o,
    output logic [WORD_SIZE-1:0] dec_instr_o,
    output logic [REG_SIZE-1:0]  dec_rs1_o,
    output logic [REG_SIZE-1:0]  dec_rs2_o,
    output logic [REG_SIZE-1:0]  dec_rd_o,
    output logic [WORD_SIZE-1:0] dec_imm_o,
    output logic                 dec_rf_we_o,
    output logic                 dec_mem_rd_o,
    output logic                 dec_mem_wr_o,
    output logic [1:0]           dec_mem_size_o,
    output logic                 dec_mem_sext_o,
    output logic                 dec_illegal_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic                 valid;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
        logic [REG_SIZE-1:0]  rs1;
        logic [REG_SIZE-1:0]  rs2;
        logic [REG_SIZE-1:0]  rd;
        logic [WORD_SIZE-1:0] imm;
        logic                 rf_we;
        logic                 mem_rd;
        logic                 mem_wr;
        logic [1:0]           mem_size;
        logic                 mem_sext;
        logic                 illegal;
    } dec_t;

    logic [WORD_SIZE-1:0] instr_mem_q [DEPTH];
    logic [WORD_SIZE-1:0] instr_mem_d [DEPTH];
    logic [WORD_SIZE-1:0] pc_mem_q    [DEPTH];
    logic [WORD_SIZE-1:0] pc_mem_d    [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 fetch_ready_q, fetch_ready_d;
    logic                 halt_q, halt_d;
    dec_t                 dec_q, dec_d;

    logic                 push;
    logic                 pop;
    logic [WORD_SIZE-1:0] head_instr;
    logic [6:0]           funct7;
    logic [2:0]           funct3;
    logic [31:0]          imm32;
    logic                 rf_we;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [1:0]           mem_size;
    logic                 mem_sext;
    logic                 illegal;

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign funct7     = head_instr[31:25];
    assign funct3     = head_instr[14:12];

    // Combinational decode of the queue head: immediate format, enables, legality
    always_comb begin
        imm32    = '0;
        rf_we    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_size = '0;
        mem_sext = 1'b0;
        illegal  = 1'b0;
        case (head_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {head_instr[31:12], 12'b0};
                rf_we = 1'b1;
            end
            OPC_JAL: begin
                imm32 = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20],
                         head_instr[30:21], 1'b0};
                rf_we = 1'b1;
            end
            OPC_JALR: begin
                imm32   = {{20{head_instr[31]}}, head_instr[31:20]};
                rf_we   = 1'b1;
                illegal = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                imm32   = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25],
                           head_instr[11:8], 1'b0};
                illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                imm32    = {{20{head_instr[31]}}, head_instr[31:20]};
                rf_we    = 1'b1;
                mem_rd   = 1'b1;
                mem_size = funct3[1:0];
                mem_sext = ~funct3[2];
                illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                imm32    = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
                mem_wr   = 1'b1;
                mem_size = funct3[1:0];
                illegal  = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                imm32   = {{20{head_instr[31]}}, head_instr[31:20]};
                rf_we   = 1'b1;
                illegal = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                          ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_OP: begin
                rf_we   = 1'b1;
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            end
            default: illegal = 1'b1;
        endcase
        if (head_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            imm32  = '0;
            rf_we  = 1'b0;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
        if (SUPPRESS_X0_WE && (head_instr[11:7] == 5'd0)) begin
            rf_we = 1'b0;
        end
    end

    // Queue bookkeeping: push/pop, pointers, count, registered ready and halt
    always_comb begin
        push          = fetch_valid_i && fetch_ready_q;
        pop           = (count_q != '0) && !halt_q && (!dec_q.valid || dec_ready_i);
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        halt_d        = halt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halt_d   = 1'b0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = fetch_instr_i;
                pc_mem_d[wr_ptr_q]    = fetch_pc_i;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (STALL_ON_ILLEGAL && illegal) begin
                    halt_d = 1'b1;
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        fetch_ready_d = (count_d < CNT_W'(DEPTH));
    end

    // Output stage: load on pop, drop on consume, clear on flush
    always_comb begin
        dec_d = dec_q;
        if (flush_i) begin
            dec_d.valid = 1'b0;
        end else if (pop) begin
            dec_d.valid    = 1'b1;
            dec_d.pc       = pc_mem_q[rd_ptr_q];
            dec_d.instr    = head_instr;
            dec_d.rs1      = REG_SIZE'(head_instr[19:15]);
            dec_d.rs2      = REG_SIZE'(head_instr[24:20]);
            dec_d.rd       = REG_SIZE'(head_instr[11:7]);
            dec_d.imm      = WORD_SIZE'($signed(imm32));
            dec_d.rf_we    = rf_we;
            dec_d.mem_rd   = mem_rd;
            dec_d.mem_wr   = mem_wr;
            dec_d.mem_size = mem_size;
            dec_d.mem_sext = mem_sext;
            dec_d.illegal  = illegal;
        end else if (dec_q.valid && dec_ready_i) begin
            dec_d.valid = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_mem_q   <= '{default: '0};
            pc_mem_q      <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_ready_q <= 1'b1;
            halt_q        <= 1'b0;
            dec_q         <= '0;
        end else begin
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fetch_ready_q <= fetch_ready_d;
            halt_q        <= halt_d;
            dec_q         <= dec_d;
        end
    end

    assign fetch_ready_o  = fetch_ready_q;
    assign dec_valid_o    = dec_q.valid;
    assign dec_pc_o       = dec_q.pc;
    assign dec_instr_o    = dec_q.instr;
    assign dec_rs1_o      = dec_q.rs1;
    assign dec_rs2_o      = dec_q.rs2;
    assign dec_rd_o       = dec_q.rd;
    assign dec_imm_o      = dec_q.imm;
    assign dec_rf_we_o    = dec_q.rf_we;
    assign dec_mem_rd_o   = dec_q.mem_rd;
    assign dec_mem_wr_o   = dec_q.mem_wr;
    assign dec_mem_size_o = dec_q.mem_size;
    assign dec_mem_sext_o = dec_q.mem_sext;
    assign dec_illegal_o  = dec_q.illegal;

endmodule

// File: tb/tb_segre_decode_queue.sv
// Bench for segre_decode_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_segre_decode_queue;

    localparam int unsigned W = 32;
    localparam int unsigned R = 5;
    localparam int unsigned D = 4;
    localparam bit STALL = 1'b1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         fv = 1'b0;
    logic         dready = 1'b0;
    logic [W-1:0] fetch_instr = '0;
    logic [W-1:0] fetch_pc = '0;
    logic         fready, dvalid;
    logic [W-1:0] dpc, dinstr, dimm;
    logic [R-1:0] drs1, drs2, drd;
    logic         drf_we, dmem_rd, dmem_wr, dsext, dillegal;
    logic [1:0]   dsize;

    always #5 clk = ~clk;

    segre_decode_queue #(
        .WORD_SIZE(W), .REG_SIZE(R), .DEPTH(D),
        .STALL_ON_ILLEGAL(STALL), .SUPPRESS_X0_WE(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fetch_valid_i(fv), .fetch_ready_o(fready),
        .fetch_instr_i(fetch_instr), .fetch_pc_i(fetch_pc),
        .dec_valid_o(dvalid), .dec_ready_i(dready),
        .dec_pc_o(dpc), .dec_instr_o(dinstr),
        .dec_rs1_o(drs1), .dec_rs2_o(drs2), .dec_rd_o(drd),
        .dec_imm_o(dimm), .dec_rf_we_o(drf_we),
        .dec_mem_rd_o(dmem_rd), .dec_mem_wr_o(dmem_wr),
        .dec_mem_size_o(dsize), .dec_mem_sext_o(dsext),
        .dec_illegal_o(dillegal)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef struct packed {
        logic [31:0] imm;
        logic        rf_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  size;
        logic        sext;
        logic        illegal;
    } exp_t;

    entry_t q[$];
    entry_t out_e;
    bit     out_v = 1'b0;
    bit     halted = 1'b0;
    int     total = 0;
    int     bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder: opcode table, legality rules, immediates rebuilt by arithmetic shifts
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit ill, writes;
        int fmt;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0; ill = 1'b0; writes = 1'b0; fmt = 0;
        case (op)
            7'h37, 7'h17: begin fmt = 4; writes = 1'b1; end
            7'h6F: begin fmt = 5; writes = 1'b1; end
            7'h67: begin fmt = 1; writes = 1'b1; ill = (f3 != 0); end
            7'h63: begin fmt = 3; ill = (f3 inside {3'd2, 3'd3}); end
            7'h03: begin
                fmt = 1; writes = 1'b1; e.mem_rd = 1'b1;
                e.size = f3[1:0]; e.sext = !f3[2];
                ill = (f3 inside {3'd3, 3'd6, 3'd7});
            end
            7'h23: begin fmt = 2; e.mem_wr = 1'b1; e.size = f3[1:0]; ill = (f3 > 2); end
            7'h13: begin
                fmt = 1; writes = 1'b1;
                ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
            end
            7'h33: begin writes = 1'b1; ill = !(f7 == 0 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5})); end
            default: ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) ill = 1'b1;
        e.illegal = ill;
        if (!ill) begin
            case (fmt)
                1: e.imm = $signed(w) >>> 20;
                2: e.imm = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
                3: e.imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19;
                4: e.imm = w & 32'hFFFF_F000;
                5: e.imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}) >>> 11;
                default: e.imm = '0;
            endcase
        end
        e.rf_we  = writes && !ill && (w[11:7] != 5'd0);
        e.mem_rd = e.mem_rd && !ill;
        e.mem_wr = e.mem_wr && !ill;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        check_eq("fetch_ready", fready, (q.size() < D));
        check_eq("dec_valid", dvalid, out_v);
        if (out_v) begin
            e = ref_decode(out_e.instr);
            check_eq("pc", dpc, out_e.pc);
            check_eq("instr", dinstr, out_e.instr);
            check_eq("rs1", drs1, out_e.instr[19:15]);
            check_eq("rs2", drs2, out_e.instr[24:20]);
            check_eq("rd", drd, out_e.instr[11:7]);
            check_eq("imm", dimm, e.imm);
            check_eq("rf_we", drf_we, e.rf_we);
            check_eq("mem_rd", dmem_rd, e.mem_rd);
            check_eq("mem_wr", dmem_wr, e.mem_wr);
            check_eq("sext", dsext, e.sext);
            check_eq("illegal", dillegal, e.illegal);
            if (e.mem_rd || e.mem_wr) check_eq("mem_size", dsize, e.size);
        end
    endtask

    // One clock: check at negedge, drive inputs, advance the model at posedge
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] p,
                         input bit rdy, input bit fl);
        bit push, pop;
        exp_t e;
        @(negedge clk);
        check_outputs();
        fv = v; fetch_instr = ins; fetch_pc = p; dready = rdy; flush = fl;
        push = v && (q.size() < D);
        pop  = (q.size() > 0) && !halted && (!out_v || rdy);
        @(posedge clk);
        if (fl) begin
            q.delete(); out_v = 1'b0; halted = 1'b0;
        end else begin
            if (pop) begin
                out_e = q.pop_front();
                out_v = 1'b1;
                e = ref_decode(out_e.instr);
                if (STALL && e.illegal) halted = 1'b1;
            end else if (out_v && rdy) begin
                out_v = 1'b0;
            end
            if (push) q.push_back('{instr: ins, pc: p});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; fv = 1'b0; dready = 1'b0; fetch_instr = '0; fetch_pc = '0;
        @(posedge clk);
        q.delete(); out_v = 1'b0; halted = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", fready, 1);
        check_eq("rst_valid", dvalid, 0);
        check_eq("rst_pc", dpc, 0);
        check_eq("rst_instr", dinstr, 0);
        check_eq("rst_regs", {drs1, drs2, drd}, 0);
        check_eq("rst_imm", dimm, 0);
        check_eq("rst_flags", {drf_we, dmem_rd, dmem_wr, dsize, dsext, dillegal}, 0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned k, s;
        w = $urandom;
        k = $urandom_range(0, 11);
        s = $urandom_range(0, 2);
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7, 8: w[6:0] = 7'h13;
            9: w[6:0] = 7'h33;
            default: ;
        endcase
        if (k inside {7, 8, 9} && s != 2) w[31:25] = (s == 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        do_reset();

        // addi x1,x0,5: one-cycle latency
        cycle(1, 32'h0050_0093, 32'h100, 1, 0);
        cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("addi_valid", dvalid, 1);
        check_eq("addi_rd", drd, 1);
        check_eq("addi_rs1", drs1, 0);
        check_eq("addi_imm", dimm, 5);
        check_eq("addi_we", drf_we, 1);
        check_eq("addi_ill", dillegal, 0);

        // lw then sw
        cycle(1, 32'h0080_A103, 32'h104, 1, 0);
        cycle(1, 32'h0020_A223, 32'h108, 1, 0);
        #1;
        check_eq("lw_imm", dimm, 8);
        check_eq("lw_mem_rd", dmem_rd, 1);
        check_eq("lw_size", dsize, 2);
        check_eq("lw_sext", dsext, 1);
        check_eq("lw_we", drf_we, 1);
        cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("sw_imm", dimm, 4);
        check_eq("sw_mem_wr", dmem_wr, 1);
        check_eq("sw_we", drf_we, 0);

        // beq backwards and lui
        cycle(1, 32'hFE00_0EE3, 32'h10C, 1, 0);
        cycle(1, 32'h1234_52B7, 32'h110, 1, 0);
        #1;
        check_eq("beq_imm", dimm, 32'hFFFF_FFFC);
        check_eq("beq_we", drf_we, 0);
        cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("lui_imm", dimm, 32'h1234_5000);
        check_eq("lui_rd", drd, 5);
        cycle(0, 0, 0, 1, 0);

        // backpressure: fill to DEPTH behind a held output
        for (int k = 0; k < 6; k++)
            cycle(1, 32'h0000_0093 | (k + 1) << 7 | k << 20, 32'h200 + 4 * k, 0, 0);
        #1;
        check_eq("full_ready", fready, 0);
        check_eq("full_held_pc", dpc, 32'h200);
        cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("ready_after_pop", fready, 1);
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, 1, 0);

        // illegal halts issue until flush
        cycle(1, 32'h0000_0000, 32'h300, 1, 0);
        cycle(1, 32'h0050_0093, 32'h304, 1, 0);
        #1;
        check_eq("ill_flag", dillegal, 1);
        check_eq("ill_enables", {drf_we, dmem_rd, dmem_wr}, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("halt_no_valid", dvalid, 0);
        cycle(0, 0, 0, 1, 1);
        #1;
        check_eq("flush_ready", fready, 1);
        check_eq("flush_valid", dvalid, 0);
        cycle(1, 32'h0030_0113, 32'h308, 1, 0);
        cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("post_flush_valid", dvalid, 1);
        check_eq("post_flush_pc", dpc, 32'h308);
        cycle(0, 0, 0, 1, 0);

        // flush against a push into a full queue
        for (int k = 0; k < 6; k++) cycle(1, 32'h0010_0093, 32'h400 + 4 * k, 0, 0);
        cycle(1, 32'h0070_0393, 32'h999, 0, 1);
        #1;
        check_eq("flush_full_valid", dvalid, 0);
        check_eq("flush_full_ready", fready, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        #1;
        check_eq("flush_dropped", dvalid, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            w = rand_instr();
            cycle($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 9) < 7,
                  ($urandom_range(0, 49) == 0) || (halted && $urandom_range(0, 3) == 0));
        end
        cycle(0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
